// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the async FIFO pointer stages (write and read side).
//   ADDR_W_DEFAULT : default RAM address width (depth = 2**ADDR_W)
//   PTR_W_DEFAULT  : default pointer width (ADDR_W + 1, extra wrap bit)
//   bin2gray       : binary -> reflected gray code
//   gray2bin       : reflected gray code -> binary
//   full_gray      : the read gray pointer as the write pointer would look
//                    when exactly one full lap ahead (top two bits inverted)
// The helpers work on a 32-bit container so one copy serves every pointer
// width; callers zero-extend the argument and size-cast the result.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int PTR_W_DEFAULT  = ADDR_W_DEFAULT + 1;

  // Binary to gray: each gray bit is the XOR of adjacent binary bits.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: running XOR from the MSB down. Zero-extended upper bits
  // stay zero, so the low bits come out right for any narrower pointer.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // In gray code, "binary + depth" is the same value with its top two bits
  // inverted; n is the pointer width (ADDR_W + 1).
  function automatic logic [31:0] full_gray(input logic [31:0] g, input int n);
    logic [31:0] mask;
    mask = 32'd3 << (n - 2);
    return g ^ mask;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_wptr_full_if.sv
// -----------------------------------------------------------------------------
// fifo_wptr_full_if
// Producer-side bundle of the write pointer / full-flag stage.
//   wr_en           : write request from the producer
//   rptr_gray_async : read gray pointer, still in the read clock domain
//   wr_ok           : write accepted this cycle (RAM write enable)
//   wr_addr         : RAM write address
//   wptr_gray       : registered write gray pointer, to the read domain
//   full            : FIFO full (registered)
//   level           : occupancy seen from the write side (registered)
//   overflow        : one-cycle pulse when a write is dropped
//   almost_full     : only when FIFO_ALMOST_FULL_EN is defined
// Modports: master = producer / environment, slave = the pointer stage.
// -----------------------------------------------------------------------------
interface fifo_wptr_full_if #(
  parameter int ADDR_W = fifo_pkg::ADDR_W_DEFAULT
);

  logic              wr_en;
  logic [ADDR_W:0]   rptr_gray_async;
  logic              wr_ok;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   wptr_gray;
  logic              full;
  logic [ADDR_W:0]   level;
  logic              overflow;
`ifdef FIFO_ALMOST_FULL_EN
  logic              almost_full;
`endif

  modport master (
    output wr_en,
    output rptr_gray_async,
    input  wr_ok,
    input  wr_addr,
    input  wptr_gray,
    input  full,
    input  level,
`ifdef FIFO_ALMOST_FULL_EN
    input  almost_full,
`endif
    input  overflow
  );

  modport slave (
    input  wr_en,
    input  rptr_gray_async,
    output wr_ok,
    output wr_addr,
    output wptr_gray,
    output full,
    output level,
`ifdef FIFO_ALMOST_FULL_EN
    output almost_full,
`endif
    output overflow
  );

endinterface : fifo_wptr_full_if

// File: rtl/fifo_wptr_full_ptr_sync.sv
// -----------------------------------------------------------------------------
// ptr_sync
// Two-flop synchronizer for a gray-coded pointer crossing clock domains.
// Shared by the write-side and read-side pointer stages.
//   clk   : destination-domain clock
//   rst_n : synchronous active-low reset, clears both stages
//   d     : pointer from the source domain
//   q     : pointer after two destination-domain flops
// Only one bit changes per source update (gray code), so a metastable
// capture resolves to either the old or the new pointer value.
// -----------------------------------------------------------------------------
module ptr_sync #(
  parameter int WIDTH = fifo_pkg::PTR_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;

  // Two-stage capture of the foreign-domain pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
    end else begin
      sync1_r <= d;
      sync2_r <= sync1_r;
    end
  end

  assign q = sync2_r;

endmodule : ptr_sync

// File: rtl/fifo_wptr_full.sv
// -----------------------------------------------------------------------------
// fifo_wptr_full
// Write-side pointer and full-flag stage of the async FIFO.
// Holds the binary and gray write pointers, drives the RAM write address and
// strobe, synchronizes the read gray pointer into this domain and derives
// full, level and overflow from the two pointers.
//   clk   : write-domain clock
//   rst_n : synchronous active-low reset
//   bus   : fifo_wptr_full_if.slave (wr_en, rptr_gray_async in; wr_ok,
//           wr_addr, wptr_gray, full, level, overflow[, almost_full] out)
// Optional feature: define FIFO_ALMOST_FULL_EN to add the registered
// almost_full flag and the AF_THRESH parameter.
// -----------------------------------------------------------------------------
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
`ifdef FIFO_ALMOST_FULL_EN
  , parameter int AF_THRESH = (1 << ADDR_W) - 2
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_wptr_full_if.slave  bus
);

  localparam int PTR_W = ADDR_W + 1;

  // Registered state
  logic [PTR_W-1:0] wbin_r;
  logic [PTR_W-1:0] wgray_r;
  logic             full_r;
  logic [PTR_W-1:0] level_r;
  logic             overflow_r;
`ifdef FIFO_ALMOST_FULL_EN
  logic             almost_full_r;
`endif

  // Combinational terms
  logic             wr_ok_s;
  logic [PTR_W-1:0] rq2_s;
  logic [PTR_W-1:0] rbin_s;
  logic [PTR_W-1:0] wbin_next_s;
  logic [PTR_W-1:0] wgray_next_s;
  logic [PTR_W-1:0] rgray_full_s;
  logic [PTR_W-1:0] occ_next_s;
  logic             full_next_s;

  ptr_sync #(
    .WIDTH (PTR_W)
  ) u_rptr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.rptr_gray_async),
    .q     (rq2_s)
  );

  // Next pointer, accept strobe and flag inputs for this cycle.
  always_comb begin
    wr_ok_s      = 1'b0;
    rbin_s       = {PTR_W{1'b0}};
    wbin_next_s  = wbin_r;
    wgray_next_s = wgray_r;
    rgray_full_s = {PTR_W{1'b0}};
    occ_next_s   = {PTR_W{1'b0}};
    full_next_s  = 1'b0;

    // A write is dropped while full; the pointer then holds.
    wr_ok_s      = bus.wr_en & ~full_r;
    rbin_s       = PTR_W'(gray2bin(32'(rq2_s)));
    // Modulo 2**PTR_W wrap toggles the lap bit.
    wbin_next_s  = wbin_r + {{(PTR_W-1){1'b0}}, wr_ok_s};
    wgray_next_s = PTR_W'(bin2gray(32'(wbin_next_s)));
    // Full when the write pointer is one whole lap ahead of the synced read
    // pointer. The read pointer is two cycles stale, so full can only linger
    // longer than necessary, never release early.
    rgray_full_s = PTR_W'(full_gray(32'(rq2_s), PTR_W));
    if (wgray_next_s == rgray_full_s) begin
      full_next_s = 1'b1;
    end else begin
      full_next_s = 1'b0;
    end
    // Unsigned modular difference is the true occupancy while it stays
    // within one lap, which the full flag guarantees.
    occ_next_s   = wbin_next_s - rbin_s;
  end

  // Pointer and flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbin_r        <= {PTR_W{1'b0}};
      wgray_r       <= {PTR_W{1'b0}};
      full_r        <= 1'b0;
      level_r       <= {PTR_W{1'b0}};
      overflow_r    <= 1'b0;
`ifdef FIFO_ALMOST_FULL_EN
      almost_full_r <= 1'b0;
`endif
    end else begin
      wbin_r        <= wbin_next_s;
      wgray_r       <= wgray_next_s;
      full_r        <= full_next_s;
      level_r       <= occ_next_s;
      overflow_r    <= bus.wr_en & full_r;
`ifdef FIFO_ALMOST_FULL_EN
      almost_full_r <= (int'(occ_next_s) >= AF_THRESH);
`endif
    end
  end

  assign bus.wr_ok       = wr_ok_s;
  assign bus.wr_addr     = wbin_r[ADDR_W-1:0];
  assign bus.wptr_gray   = wgray_r;
  assign bus.full        = full_r;
  assign bus.level       = level_r;
  assign bus.overflow    = overflow_r;
`ifdef FIFO_ALMOST_FULL_EN
  assign bus.almost_full = almost_full_r;
`endif

endmodule : fifo_wptr_full

// File: tb/tb_fifo_wptr_full.sv
// -----------------------------------------------------------------------------
// tb_fifo_wptr_full
// Self-checking bench for fifo_wptr_full with ADDR_W = 3 (depth 8).
// The reference model counts writes and reads as plain integers; the read
// count reaches the write side two edges late, occupancy is the difference.
// -----------------------------------------------------------------------------
module tb_fifo_wptr_full;

  localparam int ADDR_W = 3;
  localparam int PTR_W  = ADDR_W + 1;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int AF     = DEPTH - 2;

  logic clk;
  logic rst_n;

  fifo_wptr_full_if #(.ADDR_W(ADDR_W)) bus ();

  fifo_wptr_full #(
    .ADDR_W (ADDR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  int  wcnt;      // total accepted writes
  int  rcnt;      // total reads in the read domain
  int  s1, s2;    // read count one and two sync stages in
  bit  m_full, m_over, m_af;
  int  m_level;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int gray_of(input int count);
    int x;
    x = count % (2 * DEPTH);
    return x ^ (x >> 1);
  endfunction

  task automatic check_regs(input string tag);
    check_eq({tag, ".wptr_gray"}, 32'(bus.wptr_gray), 32'(gray_of(wcnt)));
    check_eq({tag, ".full"},      32'(bus.full),      32'(m_full));
    check_eq({tag, ".level"},     32'(bus.level),     32'(m_level));
    check_eq({tag, ".overflow"},  32'(bus.overflow),  32'(m_over));
`ifdef FIFO_ALMOST_FULL_EN
    check_eq({tag, ".almost_full"}, 32'(bus.almost_full), 32'(m_af));
`endif
  endtask

  // Reset for n edges with wr_en held high; the whole model clears.
  task automatic reset_dut(input int n);
    rst_n = 1'b0;
    bus.wr_en = 1'b1;
    rcnt = 0;
    bus.rptr_gray_async = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    wcnt = 0; s1 = 0; s2 = 0;
    m_full = 1'b0; m_over = 1'b0; m_af = 1'b0; m_level = 0;
    check_regs("reset");
    rst_n = 1'b1;
    bus.wr_en = 1'b0;
    #1;
    check_eq("reset.wr_ok", 32'(bus.wr_ok), 32'd0);
  endtask

  // One clock: drive inputs, check combinational outputs, advance the model,
  // then check the registered outputs on the falling edge.
  task automatic step(input bit we, input int rc);
    int  synced;
    int  occ;
    bit  acc;
    bus.wr_en = we;
    rcnt = rc;
    bus.rptr_gray_async = PTR_W'(gray_of(rc));
    #1;
    acc = we && !m_full;
    check_eq("wr_ok",   32'(bus.wr_ok),   32'(acc));
    check_eq("wr_addr", 32'(bus.wr_addr), 32'(wcnt % DEPTH));
    @(posedge clk);
    synced = s2;
    s2 = s1;
    s1 = rc;
    m_over = we && m_full;
    if (acc) wcnt++;
    occ = wcnt - synced;
    m_full  = (occ == DEPTH);
    m_level = occ;
    m_af    = (occ >= AF);
    @(negedge clk);
    check_regs("step");
  endtask

  int gseq [8] = '{1, 3, 2, 6, 7, 5, 4, 12};

  initial begin
    rst_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.rptr_gray_async = '0;
    @(negedge clk);

    reset_dut(3);

    // Fill to full with the read pointer parked at 0.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 0);
      check_eq("fill.gray", 32'(bus.wptr_gray), 32'(gseq[i]));
    end
    check_eq("fill.full",  32'(bus.full),  32'd1);
    check_eq("fill.level", 32'(bus.level), 32'(DEPTH));

    // Write while full is dropped and pulses overflow once.
    step(1'b1, 0);
    check_eq("ovf.pulse", 32'(bus.overflow),  32'd1);
    check_eq("ovf.gray",  32'(bus.wptr_gray), 32'd12);
    step(1'b0, 0);
    check_eq("ovf.clear", 32'(bus.overflow),  32'd0);

    // One read: full releases on the third edge.
    step(1'b0, 1);
    step(1'b0, 1);
    check_eq("rel.still_full", 32'(bus.full), 32'd1);
    step(1'b0, 1);
    check_eq("rel.full",  32'(bus.full),  32'd0);
    check_eq("rel.level", 32'(bus.level), 32'd7);
    step(1'b1, 1);
    check_eq("rel.full_again", 32'(bus.full), 32'd1);

`ifdef FIFO_ALMOST_FULL_EN
    reset_dut(1);
    for (int i = 0; i < AF; i++) begin
      step(1'b1, 0);
      if (i == AF - 2) check_eq("af.below", 32'(bus.almost_full), 32'd0);
    end
    check_eq("af.set", 32'(bus.almost_full), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1);
    check_eq("af.clear", 32'(bus.almost_full), 32'd0);
`endif

    // Randomized traffic with many wraps and one mid-stream reset.
    reset_dut(2);
    for (int it = 0; it < 600; it++) begin
      int rc;
      bit we;
      if (it == 300) reset_dut(1);
      rc = rcnt;
      we = ($urandom_range(0, 99) < 60);
      if (rc < wcnt && $urandom_range(0, 99) < 45) rc++;
      step(we, rc);
    end
    check_eq("rand.wrapped", 32'(wcnt >= 2 * DEPTH), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fifo_wptr_full
